// File: rtl/memory_unit.sv
// Cons-cell store with a cdr-threaded free list; serves one request at a time and
// rebuilds the free list from FIRST_FREE after every reset before signalling ready.
module memory_unit #(
  parameter int    DEPTH      = 1024,
  parameter int    FIRST_FREE = 512,
  parameter string INIT_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_execute,
  input  logic [1:0]  mem_func,
  input  logic [9:0]  mem_addr0,
  input  logic [9:0]  mem_addr1,
  input  logic [3:0]  mem_type_info,
  output logic        mem_ready,
  output logic [9:0]  mem_addr,
  output logic [23:0] mem_data,
  output logic [10:0] free_count,
  output logic        oom
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_W  = 11'(DEPTH);
  localparam logic [10:0] FF_W     = 11'(FIRST_FREE);
  localparam bit          HAS_FREE = FIRST_FREE < DEPTH;
  localparam logic [9:0]  HEAD0    = HAS_FREE ? 10'(FIRST_FREE) : 10'd0;
  localparam logic [10:0] COUNT0   = HAS_FREE ? 11'(DEPTH - FIRST_FREE) : 11'd0;

  localparam logic [1:0] F_NOP  = 2'd0;
  localparam logic [1:0] F_GET  = 2'd1;
  localparam logic [1:0] F_CONS = 2'd2;
  localparam logic [1:0] F_FREE = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_RESP} state_e;

  logic [23:0] mem_q [DEPTH];
  logic [23:0] rd_q;

  state_e      state_q, state_d;
  logic [10:0] init_ptr_q, init_ptr_d;
  logic [9:0]  free_head_q, free_head_d;
  logic [10:0] free_count_q, free_count_d;
  logic        oom_q, oom_d;
  logic        ready_q, ready_d;
  logic [9:0]  addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic [1:0]  func_q, func_d;
  logic [9:0]  a0_q, a0_d, a1_q, a1_d;
  logic [3:0]  type_q, type_d;
  logic [9:0]  pend_addr_q, pend_addr_d;
  logic [23:0] pend_data_q, pend_data_d;

  logic        we, re;
  logic [9:0]  waddr, raddr;
  logic [23:0] wdata;
  logic [10:0] init_next;

  assign init_next = init_ptr_q + 11'd1;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr[AW-1:0]] <= wdata;
    if (re) rd_q <= mem_q[raddr[AW-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    free_head_d  = free_head_q;
    free_count_d = free_count_q;
    oom_d        = oom_q;
    ready_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    func_d       = func_q;
    a0_d         = a0_q;
    a1_d         = a1_q;
    type_d       = type_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    re           = 1'b0;
    raddr        = '0;
    unique case (state_q)
      S_INIT: begin
        if (init_ptr_q < DEPTH_W) begin
          we         = 1'b1;
          waddr      = init_ptr_q[9:0];
          wdata      = (init_ptr_q == DEPTH_W - 11'd1) ? 24'h0 : {14'h0, init_next[9:0]};
          init_ptr_d = init_next;
        end else begin
          free_head_d  = HEAD0;
          free_count_d = COUNT0;
          ready_d      = 1'b1;
          addr_d       = '0;
          data_d       = '0;
          state_d      = S_IDLE;
        end
      end
      S_IDLE: begin
        if (mem_execute && mem_func != F_NOP) begin
          func_d = mem_func;
          a0_d   = mem_addr0;
          a1_d   = mem_addr1;
          type_d = mem_type_info;
          if (mem_func == F_FREE) begin
            state_d = S_WR;
          end else begin
            re      = 1'b1;
            raddr   = (mem_func == F_GET) ? mem_addr0 : free_head_q;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_RESP;
        if (func_q == F_GET) begin
          pend_addr_d = a0_q;
          pend_data_d = ({1'b0, a0_q} >= DEPTH_W) ? 24'h0 : rd_q;
        end else if (free_head_q != '0) begin
          // rd_q holds the old head cell; its cdr is the next free cell
          we           = 1'b1;
          waddr        = free_head_q;
          wdata        = {type_q, a0_q, a1_q};
          free_head_d  = rd_q[9:0];
          free_count_d = free_count_q - 11'd1;
          pend_addr_d  = free_head_q;
          pend_data_d  = {type_q, a0_q, a1_q};
        end else begin
          oom_d       = 1'b1;
          pend_addr_d = '0;
          pend_data_d = '0;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        pend_addr_d = a0_q;
        pend_data_d = '0;
        // Program image and nil are never put on the free list
        if (a0_q != '0 && {1'b0, a0_q} >= FF_W && {1'b0, a0_q} < DEPTH_W) begin
          we           = 1'b1;
          waddr        = a0_q;
          wdata        = {14'h0, free_head_q};
          free_head_d  = a0_q;
          free_count_d = free_count_q + 11'd1;
        end
      end
      S_RESP: begin
        ready_d = 1'b1;
        addr_d  = pend_addr_q;
        data_d  = pend_data_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      init_ptr_q   <= FF_W;
      free_head_q  <= '0;
      free_count_q <= '0;
      oom_q        <= 1'b0;
      ready_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      func_q       <= F_NOP;
      a0_q         <= '0;
      a1_q         <= '0;
      type_q       <= '0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      free_head_q  <= free_head_d;
      free_count_q <= free_count_d;
      oom_q        <= oom_d;
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      func_q       <= func_d;
      a0_q         <= a0_d;
      a1_q         <= a1_d;
      type_q       <= type_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign mem_ready  = ready_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign free_count = free_count_q;
  assign oom        = oom_q;

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: a large (1024/512) and a tiny (16/14) instance checked against
// a queue-based free-list model with directed cases and a random request mix.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex [2];
  logic [1:0]  fn [2];
  logic [9:0]  a0 [2];
  logic [9:0]  a1 [2];
  logic [3:0]  ty [2];
  logic        rdy [2];
  logic [9:0]  ma [2];
  logic [23:0] md [2];
  logic [10:0] fc [2];
  logic        om [2];

  always #5 clk = ~clk;

  memory_unit #(.DEPTH(1024), .FIRST_FREE(512), .INIT_FILE("")) u_big (
    .clk(clk), .rst(rst), .mem_execute(ex[0]), .mem_func(fn[0]), .mem_addr0(a0[0]),
    .mem_addr1(a1[0]), .mem_type_info(ty[0]), .mem_ready(rdy[0]), .mem_addr(ma[0]),
    .mem_data(md[0]), .free_count(fc[0]), .oom(om[0]));

  memory_unit #(.DEPTH(16), .FIRST_FREE(14), .INIT_FILE("")) u_small (
    .clk(clk), .rst(rst), .mem_execute(ex[1]), .mem_func(fn[1]), .mem_addr0(a0[1]),
    .mem_addr1(a1[1]), .mem_type_info(ty[1]), .mem_ready(rdy[1]), .mem_addr(ma[1]),
    .mem_data(md[1]), .free_count(fc[1]), .oom(om[1]));

  // Reference model: free list as a queue (front = head), cell contents as an array
  int          dep [2] = '{1024, 16};
  int          ff  [2] = '{512, 14};
  int          fq  [2][$];
  int          al  [2][$];
  logic [23:0] mm  [2][1024];
  bit          moom [2];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fq[d].delete();
      al[d].delete();
      moom[d] = 1'b0;
      for (int i = ff[d]; i < dep[d]; i++) begin
        fq[d].push_back(i);
        mm[d][i] = (i == dep[d] - 1) ? 24'h0 : 24'(i + 1);
      end
    end
  endtask

  // Counts mem_ready pulses for a fixed window after reset release; also pokes
  // execute into the big instance while it is still initialising.
  task automatic wait_init();
    int first [2];
    int np [2];
    first = '{0, 0};
    np    = '{0, 0};
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1;
      ex[0] = (c >= 100 && c < 110);
      fn[0] = 2'd2;
      for (int d = 0; d < 2; d++)
        if (rdy[d]) begin
          np[d]++;
          if (first[d] == 0) first[d] = c;
        end
    end
    ex[0] = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("init_cycle%0d", d), first[d], dep[d] - ff[d] + 1);
      chk($sformatf("init_pulses%0d", d), np[d], 1);
      chk($sformatf("init_count%0d", d), fc[d], fq[d].size());
      chk($sformatf("init_oom%0d", d), om[d], 0);
      chk($sformatf("init_addr%0d", d), ma[d], 0);
    end
  endtask

  task automatic txn(int d, int f, int x0, int x1, int t, bit poke);
    logic [9:0]  ea;
    logic [23:0] ed;
    int h;
    @(negedge clk);
    ex[d] = 1'b1; fn[d] = f[1:0]; a0[d] = x0[9:0]; a1[d] = x1[9:0]; ty[d] = t[3:0];
    @(posedge clk);
    #1;
    ex[d] = 1'b0;
    if (poke) begin
      ex[d] = 1'b1; fn[d] = 2'd3; a0[d] = 10'(ff[d]);
    end
    ea = '0;
    ed = '0;
    case (f)
      1: begin
        ea = x0[9:0];
        ed = (x0 >= dep[d]) ? 24'h0 : mm[d][x0];
      end
      2: begin
        if (fq[d].size() > 0) begin
          h  = fq[d].pop_front();
          ea = h[9:0];
          ed = {t[3:0], x0[9:0], x1[9:0]};
          mm[d][h] = ed;
          al[d].push_back(h);
        end else moom[d] = 1'b1;
      end
      3: begin
        ea = x0[9:0];
        if (x0 != 0 && x0 >= ff[d] && x0 < dep[d]) begin
          mm[d][x0] = (fq[d].size() > 0) ? 24'(fq[d][0]) : 24'h0;
          fq[d].push_front(x0);
          for (int i = 0; i < al[d].size(); i++)
            if (al[d][i] == x0) begin
              al[d].delete(i);
              break;
            end
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    ex[d] = 1'b0;
    chk("rdy_early", rdy[d], 0);
    @(posedge clk);
    #1;
    chk($sformatf("rdy_f%0d", f), rdy[d], (f != 0));
    if (f != 0) begin
      chk($sformatf("addr_f%0d", f), ma[d], ea);
      chk($sformatf("data_f%0d", f), md[d], ed);
    end
    chk("free_count", fc[d], fq[d].size());
    chk("oom", om[d], moom[d]);
    if (poke) begin
      repeat (2) begin
        @(posedge clk);
        #1;
        chk("poke_no_rdy", rdy[d], 0);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ex[d] = 1'b0; fn[d] = '0; a0[d] = '0; a1[d] = '0; ty[d] = '0;
    end
    #2 rst = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", rdy[d], 0);
      chk("rst_addr", ma[d], 0);
      chk("rst_data", md[d], 0);
      chk("rst_count", fc[d], 0);
      chk("rst_oom", om[d], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_init();

    // big instance, directed
    txn(0, 2, 3, 7, 5, 0);
    chk("cons_512", ma[0], 512);
    chk("cons_data", md[0], 24'h500C07);
    txn(0, 2, 1, 2, 1, 0);
    chk("cons_513", ma[0], 513);
    txn(0, 1, 512, 0, 0, 0);
    chk("get_512", md[0], 24'h500C07);
    chk("count_510", fc[0], 510);
    txn(0, 3, 512, 0, 0, 0);
    chk("count_511", fc[0], 511);
    txn(0, 2, 9, 9, 9, 0);
    chk("realloc_512", ma[0], 512);
    txn(0, 1, 600, 0, 0, 0);
    txn(0, 1, 1023, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0);
    txn(0, 3, 5, 0, 0, 0);
    txn(0, 2, 4, 4, 2, 1);

    // small instance: exhaustion, nil free, out-of-range read
    txn(1, 2, 1, 2, 3, 0);
    txn(1, 2, 1, 2, 3, 0);
    txn(1, 2, 1, 2, 3, 0);
    chk("oom_addr", ma[1], 0);
    chk("oom_flag", om[1], 1);
    txn(1, 3, 0, 0, 0, 0);
    txn(1, 1, 20, 0, 0, 0);
    txn(1, 3, 15, 0, 0, 0);
    txn(1, 1, 15, 0, 0, 0);
    txn(1, 2, 6, 6, 6, 0);

    // big instance, random mix
    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)
        txn(0, 2, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 15), 0);
      else if (r < 6 && al[0].size() > 0)
        txn(0, 3, al[0][$urandom_range(0, al[0].size() - 1)], 0, 0, 0);
      else if (r < 8)
        txn(0, 1, $urandom_range(512, 1023), 0, 0, 0);
      else if (r == 8)
        txn(0, 3, $urandom_range(0, 511), 0, 0, 0);
      else
        txn(0, 0, 0, 0, 0, 0);
    end

    // reset while the big instance sits in RD
    @(negedge clk);
    ex[0] = 1'b1; fn[0] = 2'd1; a0[0] = 10'd512;
    @(posedge clk);
    #1;
    ex[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_rdy", rdy[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_init();
    txn(0, 2, 1, 1, 1, 0);
    chk("rebuilt_512", ma[0], 512);
    txn(0, 1, 513, 0, 0, 0);
    txn(1, 2, 0, 0, 0, 0);
    chk("small_rebuilt", ma[1], 14);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
